// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy flags.
// Holds per-request fetch context between read issue and data return.
module sync_fifo #(
    parameter int WIDTH     = 96,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int AE_LEVEL  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] HALF_LVL = CW'(DEPTH / 2);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic do_rd;
    logic do_wr;

    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

    // Flags look only at registered occupancy; no path from wr/rd.
    assign full         = (count == FULL_LVL);
    assign empty        = (count == '0);
    assign half_full    = (count >= HALF_LVL);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: ordering, flags, drop, wrap and reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_sync_fifo;

    localparam int WIDTH = 96;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             half_full;
    logic             almost_full;
    logic             almost_empty;

    int vectors = 0;
    int errs    = 0;

    sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(16), .AF_MARGIN(2), .AE_LEVEL(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .wr(wr),
        .rd(rd),
        .dout(dout),
        .full(full),
        .empty(empty),
        .half_full(half_full),
        .almost_full(almost_full),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    // {full, empty, half_full, almost_full, almost_empty}
    function automatic logic [4:0] flags();
        return {full, empty, half_full, almost_full, almost_empty};
    endfunction

    task automatic chk(input string tag,
                       input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [WIDTH-1:0] d,
                       input logic r);
        wr  = w;
        din = d;
        rd  = r;
        @(negedge clk);
        wr  = 1'b0;
        rd  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        din   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_flags", 96'(flags()), 96'(5'b01001));

        // three words in, three out
        cyc(1'b1, 96'h1, 1'b0);
        chk("wr1_empty", 96'(empty), 96'(1'b0));
        chk("wr1_dout", dout, 96'h1);
        cyc(1'b1, 96'h2, 1'b0);
        cyc(1'b1, 96'h3, 1'b0);
        chk("cnt3_flags", 96'(flags()), 96'(5'b00000));
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("rd3_dout%0d", k), dout, 96'(k));
            cyc(1'b0, '0, 1'b1);
        end
        chk("rd3_flags", 96'(flags()), 96'(5'b01001));

        // fill 0..15
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 96'(i), 1'b0);
            chk($sformatf("fill%0d_af", i + 1),
                96'(almost_full), 96'((i + 1) >= 14));
            chk($sformatf("fill%0d_hf", i + 1),
                96'(half_full), 96'((i + 1) >= 8));
            chk($sformatf("fill%0d_full", i + 1),
                96'(full), 96'((i + 1) == 16));
        end
        chk("fill_dout", dout, 96'h0);

        // 17th write is dropped
        cyc(1'b1, 96'hAA, 1'b0);
        chk("drop_flags", 96'(flags()), 96'(5'b10110));
        chk("drop_dout", dout, 96'h0);

        // simultaneous wr+rd at full
        cyc(1'b1, 96'h55, 1'b1);
        chk("wrrd_full", 96'(full), 96'(1'b1));
        chk("wrrd_dout", dout, 96'h1);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d", i), dout,
                (i == 16) ? 96'h55 : 96'(i));
            cyc(1'b0, '0, 1'b1);
        end
        chk("drain_flags", 96'(flags()), 96'(5'b01001));

        // rd+wr from empty: read ignored, write lands
        cyc(1'b1, 96'h77, 1'b1);
        chk("e_wrrd_empty", 96'(empty), 96'(1'b0));
        chk("e_wrrd_dout", dout, 96'h77);
        cyc(1'b0, '0, 1'b1);
        chk("e_wrrd_pop", 96'(empty), 96'(1'b1));

        // streaming at occupancy 1 across pointer wrap
        cyc(1'b1, 96'h100, 1'b0);
        for (int i = 1; i < 40; i++) begin
            chk($sformatf("strm_dout%0d", i - 1), dout, 96'(256 + i - 1));
            cyc(1'b1, 96'(256 + i), 1'b1);
            chk($sformatf("strm_flags%0d", i), 96'(flags()),
                96'(5'b00001));
        end
        chk("strm_last", dout, 96'h127);
        cyc(1'b0, '0, 1'b1);
        chk("strm_empty", 96'(flags()), 96'(5'b01001));

        // reset with five entries held and wr asserted
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 96'(16'hC0 + i), 1'b0);
        end
        chk("pre_rst_flags", 96'(flags()), 96'(5'b00000));
        reset = 1'b0;
        cyc(1'b1, 96'h99, 1'b0);
        reset = 1'b1;
        chk("mid_rst_flags", 96'(flags()), 96'(5'b01001));
        cyc(1'b1, 96'hBEEF, 1'b0);
        chk("post_rst_empty", 96'(empty), 96'(1'b0));
        chk("post_rst_dout", dout, 96'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-word-fall-through FIFO with occupancy flags. It decouples request issue from response return in the rasterizer fetch path. Per-request context (address, colour, depth, done) is pushed when a memory read is issued and popped when the matching read data returns. Data is not modified; order is strictly preserved.

## Interface
Parameters:
- WIDTH, 96: data word width in bits.
- DEPTH, 16: number of entries; must be a power of two, ≥ 4.
- AF_MARGIN, 2: almost_full asserts when free slots ≤ AF_MARGIN.
- AE_LEVEL, 1: almost_empty asserts when occupancy ≤ AE_LEVEL.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- din  in  WIDTH  write data.
- wr  in  1  write request; pushes din this edge if accepted.
- rd  in  1  read request; pops the head entry this edge if accepted.
- dout  out  WIDTH  head entry (show-ahead); valid whenever empty=0.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- half_full  out  1  occupancy ≥ DEPTH/2.
- almost_full  out  1  occupancy ≥ DEPTH − AF_MARGIN.
- almost_empty  out  1  occupancy ≤ AE_LEVEL.

## Operation
- State: storage array of DEPTH×WIDTH; wr_ptr and rd_ptr of log2(DEPTH) bits each; count of log2(DEPTH)+1 bits (0..DEPTH).
- Pointers wrap modulo DEPTH naturally; no special wrap handling beyond bit width.
- Accepted write: wr=1 and (full=0 or rd accepted the same cycle). Writes mem[wr_ptr] ← din and increments wr_ptr.
- Accepted read: rd=1 and empty=0. Increments rd_ptr.
- count: +1 on write only, −1 on read only, unchanged on both or neither.
- Write when full with no read: dropped; no state change.
- Read when empty: ignored; no state change. A simultaneous write still proceeds.
- Read and write both accepted when full: both happen; count stays DEPTH.
- dout = mem[rd_ptr], combinational from registered state. The consumer samples dout in the same cycle it asserts rd.
- When empty, dout shows stale mem[rd_ptr]; its value is don't-care.
- Flags are decoded from the registered count only, never from the current wr/rd.
- Reset (reset=0 at an edge): wr_ptr, rd_ptr and count ← 0. Storage contents are not cleared.
- Reset overrides any wr/rd in the same cycle, including mid-operation with entries held.

## Timing
- Reset values: empty=1, almost_empty=1, full=0, half_full=0, almost_full=0; dout don't-care.
- Write-to-dout latency: 1 cycle. A word written at edge N into an empty FIFO appears on dout and drops empty after edge N.
- Read: the entry popped at edge N is presented on dout during the cycle before edge N. After edge N, dout shows the next entry.
- All flags update one cycle after the accepting edge, with no combinational path from wr/rd.
- almost_full exists so a producer with one cycle of wr pipelining never overflows when AF_MARGIN ≥ 2.
- Back-to-back wr every cycle and rd every cycle are both sustained at full throughput.

## Test plan
- Reset then idle: empty=1, almost_empty=1, full=0, half_full=0, almost_full=0.
- Write 0x1, 0x2, 0x3 on consecutive cycles, then rd for 3 cycles:
  - dout reads 0x1, 0x2, 0x3 in order.
  - empty=1 the cycle after the third pop.
- Fill to 16 entries with values 0..15:
  - almost_full first high after the 14th write.
  - half_full after the 8th write; full after the 16th.
  - A 17th write with value 0xAA is dropped; a subsequent drain yields 0..15.
- At full, assert wr (0x55) and rd together: count stays 16, dout advances to 1, and 0x55 emerges last.
- From empty, assert rd and wr (0x77) together: empty is 0 next cycle and dout=0x77.
- Wrap-around: push/pop 40 words continuously in a streaming pattern at 1 occupancy. The sequence is preserved and the flags remain consistent.
- Reset mid-operation at count 5 with wr=1: all flags return to reset values, and the next write appears on dout.
